// File: rtl/ps2_key_ctrl_pkg.sv
// Shared definitions for the PS/2 key-event controller: FSM states,
// prefix byte constants, the event record and a bad-byte helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_PAUSE     = 8'hE1;
  localparam int         PS2_PAUSE_LEN = 7;

  // One queued key event; rpt marks a typematic repeat
  typedef struct packed {
    logic       rpt;
    logic       make;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  // 0x00 and 0xFF are keyboard error/overrun bytes, never valid codes
  function automatic logic is_bad_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous show-ahead FIFO. Head word is visible on dout while
// not empty (0 when empty). A push is accepted when full only if a pop
// happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  always_comb begin
    empty   = (wr_ptr_reg == rd_ptr_reg);
    full    = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  end

  // Storage write; contents need no reset since empty gates the output
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key-event controller: decodes E0/F0/E1 prefixes, tracks the held
// key, counts new presses and queues make/break events in a FIFO.
// Optional macro PS2_KEY_REPEAT_EN queues typematic repeats flagged with
// ev_repeat instead of dropping them.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_make,
  output logic       ev_repeat,
  output logic       held,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] press_cnt,
  output logic       overflow,
  output logic       err
);

`ifdef PS2_KEY_REPEAT_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  state_t     state_reg, state_next;
  logic [2:0] skip_reg, skip_next;
  logic       dec_fire, dec_make, dec_ext, err_set;
  logic       key_match, new_press, push_req, pop;
  logic       fifo_full, fifo_empty;
  logic [FW-1:0] fifo_din, fifo_dout;
  ps2_event_t head_ev;

  logic       held_reg, held_ext_reg, overflow_reg, err_reg;
  logic [7:0] held_code_reg, press_cnt_reg;

  // Prefix decoder: next state and the decoded key event of this byte
  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    dec_fire   = 1'b0;
    dec_make   = 1'b0;
    dec_ext    = 1'b0;
    err_set    = 1'b0;
    if (code_valid) begin
      case (state_reg)
        IDLE: begin
          if (code == PS2_EXT) begin
            state_next = EXT;
          end else if (code == PS2_BRK) begin
            state_next = BRK;
          end else if (code == PS2_PAUSE) begin
            state_next = SKIP;
            skip_next  = 3'(PS2_PAUSE_LEN);
          end else if (is_bad_byte(code)) begin
            err_set = 1'b1;
          end else begin
            dec_fire = 1'b1;
            dec_make = 1'b1;
          end
        end
        EXT: begin
          if (code == PS2_BRK) begin
            state_next = EXT_BRK;
          end else if (is_bad_byte(code)) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            dec_fire   = 1'b1;
            dec_make   = 1'b1;
            dec_ext    = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          dec_fire   = 1'b1;
          state_next = IDLE;
        end
        EXT_BRK: begin
          dec_fire   = 1'b1;
          dec_ext    = 1'b1;
          state_next = IDLE;
        end
        SKIP: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg == 3'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM and skip counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      skip_reg  <= '0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
    end
  end

  // Classify the decoded event against the held key and form the FIFO word
  always_comb begin
    key_match = held_reg && (code == held_code_reg) && (dec_ext == held_ext_reg);
    new_press = dec_fire && dec_make && !key_match;
`ifdef PS2_KEY_REPEAT_EN
    push_req  = dec_fire;
    fifo_din  = {dec_make && key_match, dec_make, dec_ext, code};
    head_ev   = fifo_dout;
`else
    push_req  = dec_fire && (!dec_make || new_press);
    fifo_din  = {dec_make, dec_ext, code};
    head_ev   = {1'b0, fifo_dout};
`endif
    pop       = !fifo_empty && ev_ready;
  end

  ps2_event_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (push_req),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Held key, press counter and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      held_reg      <= 1'b0;
      held_code_reg <= '0;
      held_ext_reg  <= 1'b0;
      press_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (new_press) begin
        held_reg      <= 1'b1;
        held_code_reg <= code;
        held_ext_reg  <= dec_ext;
        press_cnt_reg <= press_cnt_reg + 8'd1;
      end else if (dec_fire && !dec_make && key_match) begin
        held_reg <= 1'b0;
      end
      if (push_req && fifo_full && !pop) overflow_reg <= 1'b1;
      if (err_set) err_reg <= 1'b1;
    end
  end

  assign ev_valid  = !fifo_empty;
  assign ev_code   = head_ev.code;
  assign ev_ext    = head_ev.ext;
  assign ev_make   = head_ev.make;
  assign ev_repeat = head_ev.rpt;
  assign held      = held_reg;
  assign held_code = held_code_reg;
  assign held_ext  = held_ext_reg;
  assign press_cnt = press_cnt_reg;
  assign overflow  = overflow_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl with an event scoreboard.
// Honours PS2_KEY_REPEAT_EN when building expected repeat events.
module tb_ps2_key_ctrl;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic       rpt;
  } exp_ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext, ev_make, ev_repeat;
  logic       held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_cnt;
  logic       overflow, err;

  int checks = 0;
  int errors = 0;
  exp_ev_t exp_q[$];

  always #5 clk = ~clk;

  ps2_key_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_make    (ev_make),
    .ev_repeat  (ev_repeat),
    .held       (held),
    .held_code  (held_code),
    .held_ext   (held_ext),
    .press_cnt  (press_cnt),
    .overflow   (overflow),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    code_valid = 1'b1;
    code       = b;
    @(negedge clk);
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic x, input logic m, input logic r);
    exp_ev_t e;
    e.code = c; e.ext = x; e.make = m; e.rpt = r;
    exp_q.push_back(e);
  endtask

  // Compare the current head against the scoreboard front
  task automatic check_head(input string tag);
    exp_ev_t e;
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(ev_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_code"}, 32'(ev_code), 32'(e.code));
      chk({tag, "_ext"}, 32'(ev_ext), 32'(e.ext));
      chk({tag, "_make"}, 32'(ev_make), 32'(e.make));
      chk({tag, "_rpt"}, 32'(ev_repeat), 32'(e.rpt));
      $display("EV %s code=%02h ext=%0d make=%0d rpt=%0d", tag, ev_code, ev_ext, ev_make, ev_repeat);
    end
  endtask

  // Pop every queued event, one per cycle, bounded
  task automatic drain(input string tag);
    int guard = 0;
    while (ev_valid === 1'b1 && guard < 16) begin
      check_head(tag);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      guard++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  logic rpt_on;

  initial begin
`ifdef PS2_KEY_REPEAT_EN
    rpt_on = 1'b1;
`else
    rpt_on = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_code", 32'(ev_code), 0);
    chk("rst_ev_make", 32'(ev_make), 0);
    chk("rst_held", 32'(held), 0);
    chk("rst_held_code", 32'(held_code), 0);
    chk("rst_press_cnt", 32'(press_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_err", 32'(err), 0);

    // Plain make/break with one-cycle latency
    send(8'h1C); expect_ev(8'h1C, 0, 1, 0);
    chk("t1_latency", 32'(ev_valid), 1);
    chk("t1_held", 32'(held), 1);
    chk("t1_held_code", 32'(held_code), 32'h1C);
    chk("t1_cnt", 32'(press_cnt), 1);
    send(8'hF0); send(8'h1C); expect_ev(8'h1C, 0, 0, 0);
    chk("t1_released", 32'(held), 0);
    chk("t1_held_code_kept", 32'(held_code), 32'h1C);
    drain("t1");

    // Extended make/break
    send(8'hE0); send(8'h75); expect_ev(8'h75, 1, 1, 0);
    chk("t2_held", 32'(held), 1);
    chk("t2_held_ext", 32'(held_ext), 1);
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(8'h75, 1, 0, 0);
    chk("t2_released", 32'(held), 0);
    chk("t2_cnt", 32'(press_cnt), 2);
    drain("t2");

    // Typematic: 1C x5 then release
    send(8'h1C); expect_ev(8'h1C, 0, 1, 0);
    send(8'h1C); if (rpt_on) expect_ev(8'h1C, 0, 1, 1);
    send(8'h1C); if (rpt_on) expect_ev(8'h1C, 0, 1, 1);
    drain("t3a");
    send(8'h1C); if (rpt_on) expect_ev(8'h1C, 0, 1, 1);
    send(8'h1C); if (rpt_on) expect_ev(8'h1C, 0, 1, 1);
    send(8'hF0); send(8'h1C); expect_ev(8'h1C, 0, 0, 0);
    drain("t3b");
    chk("t3_cnt", 32'(press_cnt), 3);
    chk("t3_overflow", 32'(overflow), 0);

    // Overflow: DEPTH+1 distinct makes with consumer stalled
    send(8'h15); expect_ev(8'h15, 0, 1, 0);
    send(8'h1D); expect_ev(8'h1D, 0, 1, 0);
    send(8'h24); expect_ev(8'h24, 0, 1, 0);
    send(8'h2D); expect_ev(8'h2D, 0, 1, 0);
    chk("t4_no_ovf_yet", 32'(overflow), 0);
    send(8'h2C);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_held_code", 32'(held_code), 32'h2C);
    chk("t4_cnt", 32'(press_cnt), 8);
    // Push (break 2C) together with a pop while full
    send(8'hF0);
    check_head("t4_pop");
    ev_ready = 1'b1;
    send(8'h2C); expect_ev(8'h2C, 0, 0, 0);
    ev_ready = 1'b0;
    chk("t4_released", 32'(held), 0);
    drain("t4");

    // Pause sequence produces nothing, then a normal make
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("t5_pause_silent", 32'(ev_valid), 0);
    send(8'h1C); expect_ev(8'h1C, 0, 1, 0);
    drain("t5");
    chk("t5_err_clear", 32'(err), 0);
    send(8'hFF);
    chk("t5_err", 32'(err), 1);
    chk("t5_err_no_ev", 32'(ev_valid), 0);
    send(8'hF0); send(8'h1C); expect_ev(8'h1C, 0, 0, 0);
    drain("t5_idle");
    chk("t5_err_sticky", 32'(err), 1);

    // Reset mid-sequence flushes FIFO and returns to IDLE
    send(8'h29);
    send(8'hE0);
    do_reset();
    chk("t6_flushed", 32'(ev_valid), 0);
    chk("t6_cnt", 32'(press_cnt), 0);
    chk("t6_err", 32'(err), 0);
    send(8'h1C); expect_ev(8'h1C, 0, 1, 0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
